reorder_buffer_mc: RTL and testbench

Parametrised, multi-commit successor of the core's reorder buffer. Holds up to 2^ROB_WIDTH in-flight instructions in program order and accepts results from WB_PORTS writeback channels. Retires up to COMMIT_WIDTH ready entries per cycle to the register file and the load/store buffer. Detects branch mispredictions at commit and raises a registered flush with the correct PC. Sits between the decoder (issue), the reservation station and LSB (writeback), and the register file (commit and operand lookup).

---
 rtl/reorder_buffer_mc_pkg.sv | 15 +
 rtl/reorder_buffer_mc_commit_select.sv | 41 ++++
 rtl/reorder_buffer_mc.sv | 179 +++++++++++++++++
 tb/tb_reorder_buffer_mc.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_mc_pkg.sv
// Shared types and default sizes for the multi-commit reorder buffer.
package reorder_buffer_mc_pkg;

    localparam int DEF_ROB_WIDTH = 3;
    localparam int DEF_REG_WIDTH = 5;
    localparam int DEF_DEPTH     = 1 << DEF_ROB_WIDTH;

    typedef enum logic [1:0] {
        T_REG    = 2'd0,
        T_STORE  = 2'd1,
        T_BRANCH = 2'd2,
        T_EXIT   = 2'd3
    } rob_type_t;

endpackage

// File: rtl/reorder_buffer_mc_commit_select.sv
// Picks which of the two oldest entries retire this cycle and flags
// a mispredicting branch among them.
module rob_commit_select
    import reorder_buffer_mc_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2
)(
    input  logic        en,
    input  logic [1:0]  present,
    input  logic [1:0]  ready,
    input  rob_type_t   typ0,
    input  rob_type_t   typ1,
    input  logic [31:0] res0,
    input  logic [31:0] res1,
    input  logic [31:0] pred0,
    input  logic [31:0] pred1,
    output logic [1:0]  take,
    output logic        mispredict,
    output logic        mis_slot
);

    always_comb begin
        take       = '0;
        mispredict = 1'b0;
        mis_slot   = 1'b0;
        take[0] = en && present[0] && ready[0];
        // Control flow ends the commit group; one store per cycle to the LSB.
        take[1] = (COMMIT_WIDTH > 1) && take[0]
               && present[1] && ready[1]
               && (typ0 != T_BRANCH) && (typ0 != T_EXIT)
               && !((typ0 == T_STORE) && (typ1 == T_STORE));
        if (take[0] && (typ0 == T_BRANCH) && (res0 != pred0)) begin
            mispredict = 1'b1;
            mis_slot   = 1'b0;
        end else if (take[1] && (typ1 == T_BRANCH) && (res1 != pred1)) begin
            mispredict = 1'b1;
            mis_slot   = 1'b1;
        end
    end

endmodule

// File: rtl/reorder_buffer_mc.sv
// Multi-commit reorder buffer: in-order issue, multi-port writeback,
// up to two retirements per cycle, registered flush on mispredict.
module reorder_buffer_mc
    import reorder_buffer_mc_pkg::*;
#(
    parameter int ROB_WIDTH    = DEF_ROB_WIDTH,
    parameter int REG_WIDTH    = DEF_REG_WIDTH,
    parameter int WB_PORTS     = 2,
    parameter int COMMIT_WIDTH = 2
)(
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            dec_valid,
    output logic                            dec_ready,
    input  logic [1:0]                      dec_type,
    input  logic                            dec_done,
    input  logic [31:0]                     dec_res,
    input  logic [REG_WIDTH-1:0]            dec_dest,
    input  logic [31:0]                     dec_pred_pc,
    output logic [ROB_WIDTH-1:0]            dec_rob_id,
    input  logic [WB_PORTS-1:0]             wb_valid,
    input  logic [WB_PORTS*ROB_WIDTH-1:0]   wb_rob_id,
    input  logic [WB_PORTS*32-1:0]          wb_data,
    input  logic [ROB_WIDTH-1:0]            q_rob_id_j,
    input  logic [ROB_WIDTH-1:0]            q_rob_id_k,
    output logic                            q_ready_j,
    output logic                            q_ready_k,
    output logic [31:0]                     q_data_j,
    output logic [31:0]                     q_data_k,
    output logic [COMMIT_WIDTH-1:0]         commit_valid,
    output logic [COMMIT_WIDTH*REG_WIDTH-1:0] commit_reg_id,
    output logic [COMMIT_WIDTH*32-1:0]      commit_data,
    output logic [COMMIT_WIDTH*ROB_WIDTH-1:0] commit_rob_id,
    output logic                            lsb_commit_valid,
    output logic [ROB_WIDTH-1:0]            lsb_commit_rob_id,
    output logic                            flush,
    output logic [31:0]                     flush_pc,
    output logic                            halt,
    output logic [ROB_WIDTH:0]              count
);

    localparam int DEPTH = 1 << ROB_WIDTH;

    logic [DEPTH-1:0]     present;
    logic [DEPTH-1:0]     ready;
    rob_type_t            typ     [DEPTH];
    logic [31:0]          res     [DEPTH];
    logic [31:0]          pred_pc [DEPTH];
    logic [REG_WIDTH-1:0] dest    [DEPTH];
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;

    logic [ROB_WIDTH-1:0] sid [2];
    logic [1:0]           take;
    logic [1:0]           n_com;
    logic                 mispredict;
    logic                 mis_slot;
    logic                 wb_en;
    logic                 issue;
    logic [1:0]           st;

    assign sid[0]     = head;
    assign sid[1]     = head + ROB_WIDTH'(1);
    assign wb_en      = rdy_in && !flush;
    assign dec_ready  = rdy_in && (count != (ROB_WIDTH+1)'(DEPTH)) && !flush;
    assign issue      = dec_valid && dec_ready;
    assign dec_rob_id = tail;
    assign n_com      = {1'b0, take[0]} + {1'b0, take[1]};

    rob_commit_select #(.COMMIT_WIDTH(COMMIT_WIDTH)) u_sel (
        .en         (wb_en),
        .present    ({present[sid[1]], present[sid[0]]}),
        .ready      ({ready[sid[1]], ready[sid[0]]}),
        .typ0       (typ[sid[0]]),
        .typ1       (typ[sid[1]]),
        .res0       (res[sid[0]]),
        .res1       (res[sid[1]]),
        .pred0      (pred_pc[sid[0]]),
        .pred1      (pred_pc[sid[1]]),
        .take       (take),
        .mispredict (mispredict),
        .mis_slot   (mis_slot)
    );

    for (genvar s = 0; s < COMMIT_WIDTH; s++) begin : g_slot
        logic reg_c;
        assign reg_c = take[s] && (typ[sid[s]] == T_REG);
        assign commit_valid[s] = reg_c;
        assign commit_reg_id[s*REG_WIDTH +: REG_WIDTH] = reg_c ? dest[sid[s]] : '0;
        assign commit_data[s*32 +: 32] = reg_c ? res[sid[s]] : '0;
        assign commit_rob_id[s*ROB_WIDTH +: ROB_WIDTH] = reg_c ? sid[s] : '0;
    end

    assign st[0] = take[0] && (typ[sid[0]] == T_STORE);
    assign st[1] = take[1] && (typ[sid[1]] == T_STORE);
    assign lsb_commit_valid  = |st;
    assign lsb_commit_rob_id = st[0] ? sid[0] : (st[1] ? sid[1] : '0);

    logic [1:0][ROB_WIDTH-1:0] q_id;
    logic [1:0]                q_rdy;
    logic [1:0][31:0]          q_dat;

    assign q_id = {q_rob_id_k, q_rob_id_j};

    // Lower writeback channel wins, so scan from the top down.
    always_comb begin
        q_rdy = '0;
        q_dat = '0;
        for (int p = 0; p < 2; p++) begin
            if (present[q_id[p]] && ready[q_id[p]]) begin
                q_rdy[p] = 1'b1;
                q_dat[p] = res[q_id[p]];
            end
            for (int i = WB_PORTS - 1; i >= 0; i--) begin
                if (wb_en && wb_valid[i] && present[q_id[p]]
                    && (wb_rob_id[i*ROB_WIDTH +: ROB_WIDTH] == q_id[p])) begin
                    q_rdy[p] = 1'b1;
                    q_dat[p] = wb_data[i*32 +: 32];
                end
            end
        end
    end

    assign q_ready_j = q_rdy[0];
    assign q_ready_k = q_rdy[1];
    assign q_data_j  = q_dat[0];
    assign q_data_k  = q_dat[1];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            present  <= '0;
            ready    <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            flush    <= 1'b0;
            flush_pc <= '0;
            halt     <= 1'b0;
        end else if (rdy_in) begin
            flush <= 1'b0;
            if (!flush) begin
                for (int i = WB_PORTS - 1; i >= 0; i--) begin
                    if (wb_valid[i] && present[wb_rob_id[i*ROB_WIDTH +: ROB_WIDTH]]) begin
                        ready[wb_rob_id[i*ROB_WIDTH +: ROB_WIDTH]] <= 1'b1;
                        res[wb_rob_id[i*ROB_WIDTH +: ROB_WIDTH]]   <= wb_data[i*32 +: 32];
                    end
                end
                for (int s = 0; s < 2; s++) begin
                    if (take[s]) begin
                        present[sid[s]] <= 1'b0;
                        if (typ[sid[s]] == T_EXIT) halt <= 1'b1;
                    end
                end
                if (mispredict) begin
                    present  <= '0;
                    head     <= '0;
                    tail     <= '0;
                    count    <= '0;
                    flush    <= 1'b1;
                    flush_pc <= res[sid[mis_slot]];
                end else begin
                    if (issue) begin
                        present[tail] <= 1'b1;
                        ready[tail]   <= dec_done;
                        typ[tail]     <= rob_type_t'(dec_type);
                        res[tail]     <= dec_res;
                        dest[tail]    <= dec_dest;
                        pred_pc[tail] <= dec_pred_pc;
                        tail          <= tail + ROB_WIDTH'(1);
                    end
                    head  <= head + ROB_WIDTH'(n_com);
                    count <= count + (ROB_WIDTH+1)'(issue) - (ROB_WIDTH+1)'(n_com);
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed bench for reorder_buffer_mc: vector table plus hand-built
// sequences for fill/drain, pointer wrap, dual-writeback and reset-in-flush.
module tb_reorder_buffer_mc;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        dec_valid;
    logic        dec_ready;
    logic [1:0]  dec_type;
    logic        dec_done;
    logic [31:0] dec_res;
    logic [4:0]  dec_dest;
    logic [31:0] dec_pred_pc;
    logic [2:0]  dec_rob_id;
    logic [1:0]  wb_valid;
    logic [5:0]  wb_rob_id;
    logic [63:0] wb_data;
    logic [2:0]  q_rob_id_j;
    logic [2:0]  q_rob_id_k;
    logic        q_ready_j;
    logic        q_ready_k;
    logic [31:0] q_data_j;
    logic [31:0] q_data_k;
    logic [1:0]  commit_valid;
    logic [9:0]  commit_reg_id;
    logic [63:0] commit_data;
    logic [5:0]  commit_rob_id;
    logic        lsb_commit_valid;
    logic [2:0]  lsb_commit_rob_id;
    logic        flush;
    logic [31:0] flush_pc;
    logic        halt;
    logic [3:0]  count;

    int n_chk = 0;
    int n_fail = 0;

    reorder_buffer_mc dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_type(dec_type),
        .dec_done(dec_done), .dec_res(dec_res), .dec_dest(dec_dest),
        .dec_pred_pc(dec_pred_pc), .dec_rob_id(dec_rob_id),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_data(wb_data),
        .q_rob_id_j(q_rob_id_j), .q_rob_id_k(q_rob_id_k),
        .q_ready_j(q_ready_j), .q_ready_k(q_ready_k),
        .q_data_j(q_data_j), .q_data_k(q_data_k),
        .commit_valid(commit_valid), .commit_reg_id(commit_reg_id),
        .commit_data(commit_data), .commit_rob_id(commit_rob_id),
        .lsb_commit_valid(lsb_commit_valid),
        .lsb_commit_rob_id(lsb_commit_rob_id),
        .flush(flush), .flush_pc(flush_pc), .halt(halt), .count(count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        v;
        logic [1:0]  ty;
        logic        done;
        logic [31:0] dres;
        logic [4:0]  ddest;
        logic [31:0] dpred;
        logic        wv;
        logic [2:0]  wid;
        logic [31:0] wd;
        logic        e_rdy;
        logic [2:0]  e_id;
        logic [3:0]  e_cnt;
        logic [1:0]  e_cv;
        logic [31:0] e_cd1;
        logic        e_lsb;
        logic [2:0]  e_lsbid;
        logic        e_fl;
        logic [31:0] e_fpc;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        dec_valid   = 1'b0;
        dec_type    = 2'd0;
        dec_done    = 1'b0;
        dec_res     = '0;
        dec_dest    = '0;
        dec_pred_pc = '0;
        wb_valid    = '0;
        wb_rob_id   = '0;
        wb_data     = '0;
        q_rob_id_j  = '0;
        q_rob_id_k  = '0;
    endtask

    task automatic issue(input logic [1:0] ty, input logic done,
                         input logic [31:0] r, input logic [4:0] d,
                         input logic [31:0] p);
        dec_valid   = 1'b1;
        dec_type    = ty;
        dec_done    = done;
        dec_res     = r;
        dec_dest    = d;
        dec_pred_pc = p;
    endtask

    task automatic step();
        @(negedge clk_in);
        idle();
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        idle();
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1, 1, 0, 0,     0, 0,     0, 0, 0,     1, 0, 0, 0, 0,     0, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 'h11,  0, 0,     0, 0, 0,     1, 1, 1, 0, 0,     0, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 'h55,  3, 0,     0, 0, 0,     1, 2, 2, 0, 0,     0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0,     0, 0,     1, 0, 'h99,  1, 3, 3, 0, 0,     0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0,     0, 0,     0, 0, 0,     1, 3, 3, 0, 0,     1, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0,     0, 0,     0, 0, 0,     1, 3, 2, 2, 'h55,  1, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 0,     0, 0,     0, 0, 0,     1, 3, 0, 0, 0,     0, 0, 0, 0};
        tbl[7]  = '{1, 2, 0, 0,     0, 'h100, 0, 0, 0,     1, 3, 0, 0, 0,     0, 0, 0, 0};
        tbl[8]  = '{1, 0, 1, 1,     1, 0,     0, 0, 0,     1, 4, 1, 0, 0,     0, 0, 0, 0};
        tbl[9]  = '{1, 0, 1, 2,     2, 0,     1, 3, 'h200, 1, 5, 2, 0, 0,     0, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0,     0, 0,     0, 0, 0,     1, 6, 3, 0, 0,     0, 0, 0, 0};
        tbl[11] = '{1, 0, 1, 7,     7, 0,     0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 1, 'h200};
        tbl[12] = '{0, 0, 0, 0,     0, 0,     0, 0, 0,     1, 0, 0, 0, 0,     0, 0, 0, 0};

        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle();
        do_reset();
        #1;
        chk("rst dec_ready", 32'(dec_ready), 1);
        chk("rst count", 32'(count), 0);
        chk("rst flush", 32'(flush), 0);
        chk("rst flush_pc", flush_pc, 0);
        chk("rst halt", 32'(halt), 0);
        chk("rst commit_valid", 32'(commit_valid), 0);
        chk("rst lsb_valid", 32'(lsb_commit_valid), 0);
        chk("rst dec_rob_id", 32'(dec_rob_id), 0);
        chk("rst q_ready_j", 32'(q_ready_j), 0);

        // store pairing and branch mispredict, one row per cycle
        for (int i = 0; i < 13; i++) begin
            dec_valid   = tbl[i].v;
            dec_type    = tbl[i].ty;
            dec_done    = tbl[i].done;
            dec_res     = tbl[i].dres;
            dec_dest    = tbl[i].ddest;
            dec_pred_pc = tbl[i].dpred;
            wb_valid    = {1'b0, tbl[i].wv};
            wb_rob_id   = {3'd0, tbl[i].wid};
            wb_data     = {32'd0, tbl[i].wd};
            #1;
            chk($sformatf("v%0d dec_ready", i), 32'(dec_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d dec_rob_id", i), 32'(dec_rob_id), 32'(tbl[i].e_id));
            chk($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d commit_valid", i), 32'(commit_valid), 32'(tbl[i].e_cv));
            chk($sformatf("v%0d commit_data1", i), commit_data[63:32], tbl[i].e_cd1);
            chk($sformatf("v%0d lsb_valid", i), 32'(lsb_commit_valid), 32'(tbl[i].e_lsb));
            chk($sformatf("v%0d lsb_id", i), 32'(lsb_commit_rob_id), 32'(tbl[i].e_lsbid));
            chk($sformatf("v%0d flush", i), 32'(flush), 32'(tbl[i].e_fl));
            if (tbl[i].e_fl) chk($sformatf("v%0d flush_pc", i), flush_pc, tbl[i].e_fpc);
            step();
        end

        // fill to DEPTH with unresolved entries
        for (int i = 0; i < 8; i++) begin
            issue(2'd0, 1'b0, 32'd0, 5'(i + 1), 32'd0);
            #1;
            chk($sformatf("fill%0d id", i), 32'(dec_rob_id), 32'(i));
            chk($sformatf("fill%0d count", i), 32'(count), 32'(i));
            chk($sformatf("fill%0d ready", i), 32'(dec_ready), 1);
            step();
        end
        issue(2'd0, 1'b1, 32'd0, 5'd1, 32'd0);
        #1;
        chk("full count", 32'(count), 8);
        chk("full dec_ready", 32'(dec_ready), 0);
        step();
        #1;
        chk("full hold count", 32'(count), 8);

        // write back in reverse, two per cycle, with bypass lookup on id 3
        for (int c = 0; c < 4; c++) begin
            wb_valid   = 2'b11;
            wb_rob_id  = {3'(6 - 2*c), 3'(7 - 2*c)};
            wb_data    = {32'h1000 + 32'(6 - 2*c), 32'h1000 + 32'(7 - 2*c)};
            q_rob_id_j = 3'd3;
            q_rob_id_k = 3'd0;
            #1;
            chk($sformatf("wb%0d q_ready_j", c), 32'(q_ready_j), (c >= 2) ? 1 : 0);
            chk($sformatf("wb%0d q_data_j", c), q_data_j, (c >= 2) ? 32'h1003 : 32'h0);
            chk($sformatf("wb%0d q_ready_k", c), 32'(q_ready_k), (c == 3) ? 1 : 0);
            chk($sformatf("wb%0d commit_valid", c), 32'(commit_valid), 0);
            step();
        end
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("drain%0d cv", c), 32'(commit_valid), 3);
            chk($sformatf("drain%0d rob0", c), 32'(commit_rob_id[2:0]), 32'(2*c));
            chk($sformatf("drain%0d rob1", c), 32'(commit_rob_id[5:3]), 32'(2*c + 1));
            chk($sformatf("drain%0d data0", c), commit_data[31:0], 32'h1000 + 32'(2*c));
            chk($sformatf("drain%0d data1", c), commit_data[63:32], 32'h1000 + 32'(2*c + 1));
            chk($sformatf("drain%0d reg0", c), 32'(commit_reg_id[4:0]), 32'(2*c + 1));
            chk($sformatf("drain%0d count", c), 32'(count), 32'(8 - 2*c));
            step();
        end
        #1;
        chk("drained count", 32'(count), 0);

        // same id on both channels: channel 0 must win
        issue(2'd0, 1'b0, 32'd0, 5'd9, 32'd0);
        #1;
        chk("dup id", 32'(dec_rob_id), 0);
        step();
        wb_valid  = 2'b11;
        wb_rob_id = {3'd0, 3'd0};
        wb_data   = {32'hBBBB, 32'hAAAA};
        step();
        #1;
        chk("dup cv", 32'(commit_valid), 1);
        chk("dup data", commit_data[31:0], 32'hAAAA);
        chk("dup reg", 32'(commit_reg_id[4:0]), 9);
        step();
        #1;
        chk("dup count", 32'(count), 0);

        // pointer wrap: full start, then one issue and one retire per cycle
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue(2'd0, 1'b0, 32'd0, 5'd1, 32'd0);
            step();
        end
        for (int c = 0; c < 20; c++) begin
            issue(2'd0, 1'b0, 32'd0, 5'd1, 32'd0);
            wb_valid  = 2'b01;
            wb_rob_id = {3'd0, 3'(c % 8)};
            wb_data   = {32'd0, 32'(c)};
            #1;
            chk($sformatf("wrap%0d count", c), 32'(count), (c < 2) ? 8 : 7);
            chk($sformatf("wrap%0d ready", c), 32'(dec_ready), (c < 2) ? 0 : 1);
            chk($sformatf("wrap%0d id", c), 32'(dec_rob_id), (c < 2) ? 0 : (c - 2) % 8);
            chk($sformatf("wrap%0d cv", c), 32'(commit_valid), (c == 0) ? 0 : 1);
            if (c >= 1) chk($sformatf("wrap%0d rob0", c), 32'(commit_rob_id[2:0]), (c - 1) % 8);
            step();
        end

        // halt on EXIT, then reset during the flush cycle
        do_reset();
        issue(2'd3, 1'b1, 32'd0, 5'd0, 32'd0);
        step();
        #1;
        chk("exit halt pre", 32'(halt), 0);
        step();
        #1;
        chk("exit halt", 32'(halt), 1);
        issue(2'd2, 1'b0, 32'd0, 5'd0, 32'h100);
        step();
        for (int i = 0; i < 4; i++) begin
            issue(2'd0, 1'b0, 32'd0, 5'(i + 1), 32'd0);
            step();
        end
        #1;
        chk("fl count", 32'(count), 5);
        wb_valid  = 2'b01;
        wb_rob_id = {3'd0, 3'd1};
        wb_data   = {32'd0, 32'h300};
        step();
        #1;
        chk("fl pre flush", 32'(flush), 0);
        step();
        #1;
        chk("fl flush", 32'(flush), 1);
        chk("fl flush_pc", flush_pc, 32'h300);
        chk("fl dec_ready", 32'(dec_ready), 0);
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("rf count", 32'(count), 0);
        chk("rf flush", 32'(flush), 0);
        chk("rf halt", 32'(halt), 0);
        chk("rf dec_ready", 32'(dec_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
